// File: rtl/acc_pkg.sv
// Shared accelerator types plus channel-count and channel-ID definitions
// used by the multi-channel memory controller.
package acc_pkg;

  typedef logic [31:0] data_t;
  typedef logic [31:0] addr_t;

  localparam int MEM_CTL_NUM_CH = 4;

  typedef logic [$clog2(MEM_CTL_NUM_CH)-1:0] ch_id_t;

endpackage

// File: rtl/mem_ctl_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after its pointer
// and moves the pointer past the winner only when the grant is consumed.
module mem_ctl_rr_arb #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic           advance_i,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_vld_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  int             idx;

  // Scan from the far end down so the lowest offset from ptr wins last.
  always_comb begin
    gnt_id_o  = '0;
    gnt_vld_o = 1'b0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req_i[IDW'(idx)]) begin
        gnt_id_o  = IDW'(idx);
        gnt_vld_o = 1'b1;
      end
    end
    ptr_d = ptr_q;
    if (advance_i && gnt_vld_o)
      ptr_d = (gnt_id_o == IDW'(N - 1)) ? '0 : gnt_id_o + IDW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_ctl_mc.sv
// Multi-channel memory controller: RR read/write arbitration, in-order read
// routing through an ID FIFO, sticky unsolicited-rvalid error.
// Optional per-channel handshake counters under MEM_CTL_MC_PERF_EN.
module mem_ctl_mc
  import acc_pkg::*;
#(
  parameter int NUM_CH    = MEM_CTL_NUM_CH,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [DATA_W-1:0]              mem_rdata_i,
  input  logic                           mem_rvalid_i,
  input  logic                           mem_rready_i,
  input  logic                           mem_wready_i,
  output logic                           mem_rden_o,
  output logic [ADDR_W-1:0]              mem_raddr_o,
  output logic                           mem_wren_o,
  output logic [ADDR_W-1:0]              mem_waddr_o,
  output logic [DATA_W-1:0]              mem_wdata_o,
  input  logic [NUM_CH-1:0]              ctl_rden_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ctl_raddr_i,
  output logic [NUM_CH-1:0]              ctl_rready_o,
  output logic [NUM_CH-1:0]              ctl_rvalid_o,
  output logic [DATA_W-1:0]              ctl_rdata_o,
  input  logic [NUM_CH-1:0]              ctl_wren_i,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ctl_waddr_i,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ctl_wdata_i,
  output logic [NUM_CH-1:0]              ctl_wready_o,
  output logic                           err_o
`ifdef MEM_CTL_MC_PERF_EN
  ,
  output logic [NUM_CH-1:0][31:0]        perf_rd_cnt_o,
  output logic [NUM_CH-1:0][31:0]        perf_wr_cnt_o
`endif
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int CW  = PW + 1;

  logic [CHW-1:0] rgnt, wgnt;
  logic           rgnt_vld, wgnt_vld;
  logic           rd_hs, wr_hs, pop, fifo_full, fifo_empty;

  logic [CHW-1:0] fifo_q [MAX_OUTST];
  logic [CHW-1:0] fifo_d [MAX_OUTST];
  logic [PW-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;

  mem_ctl_rr_arb #(.N(NUM_CH)) u_rd_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (ctl_rden_i),
    .advance_i (rd_hs),
    .gnt_id_o  (rgnt),
    .gnt_vld_o (rgnt_vld)
  );

  mem_ctl_rr_arb #(.N(NUM_CH)) u_wr_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (ctl_wren_i),
    .advance_i (wr_hs),
    .gnt_id_o  (wgnt),
    .gnt_vld_o (wgnt_vld)
  );

  // A full FIFO blocks the request even when a pop frees a slot this cycle.
  always_comb begin
    fifo_full   = (cnt_q == CW'(MAX_OUTST));
    fifo_empty  = (cnt_q == '0);
    mem_rden_o  = rgnt_vld & ~fifo_full;
    rd_hs       = mem_rden_o & mem_rready_i;
    pop         = mem_rvalid_i & ~fifo_empty;
    mem_raddr_o = rgnt_vld ? ctl_raddr_i[rgnt] : '0;

    ctl_rready_o = '0;
    if (rd_hs) ctl_rready_o[rgnt] = 1'b1;

    ctl_rvalid_o = '0;
    ctl_rdata_o  = '0;
    if (pop) begin
      ctl_rvalid_o[fifo_q[rp_q]] = 1'b1;
      ctl_rdata_o                = mem_rdata_i;
    end

    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (rd_hs) begin
      fifo_d[wp_q] = rgnt;
      wp_d         = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
    cnt_d = cnt_q + CW'(rd_hs) - CW'(pop);

    err_d = err_q | (mem_rvalid_i & fifo_empty);
  end

  always_comb begin
    mem_wren_o   = wgnt_vld;
    wr_hs        = wgnt_vld & mem_wready_i;
    mem_waddr_o  = wgnt_vld ? ctl_waddr_i[wgnt] : '0;
    mem_wdata_o  = wgnt_vld ? ctl_wdata_i[wgnt] : '0;
    ctl_wready_o = '0;
    if (wgnt_vld) ctl_wready_o[wgnt] = mem_wready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
    fifo_q <= fifo_d;
  end

  assign err_o = err_q;

`ifdef MEM_CTL_MC_PERF_EN
  logic [NUM_CH-1:0][31:0] perf_rd_q, perf_rd_d, perf_wr_q, perf_wr_d;

  // Saturating counters: stick at all-ones rather than wrapping.
  always_comb begin
    perf_rd_d = perf_rd_q;
    perf_wr_d = perf_wr_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rd_hs && rgnt == CHW'(c) && perf_rd_q[c] != '1)
        perf_rd_d[c] = perf_rd_q[c] + 32'd1;
      if (wr_hs && wgnt == CHW'(c) && perf_wr_q[c] != '1)
        perf_wr_d[c] = perf_wr_q[c] + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_rd_q <= '0;
      perf_wr_q <= '0;
    end else begin
      perf_rd_q <= perf_rd_d;
      perf_wr_q <= perf_wr_d;
    end
  end

  assign perf_rd_cnt_o = perf_rd_q;
  assign perf_wr_cnt_o = perf_wr_q;
`endif

endmodule
